branch_predictor: RTL and testbench

Dynamic branch predictor and EX-stage branch resolver for the 5-stage pipeline CPU. It predicts taken/not-taken and the target for the instruction in IF using a direct-mapped branch target buffer with 2-bit saturating counters. It resolves the instruction in EX against that prediction and drives `Nexttype` and the redirect PC into the hazard detection unit. It also trains the table and keeps branch/mispredict statistics.

---
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating counters plus EX-stage branch
// resolution. Predicts for the fetch PC, resolves the EX instruction against
// the prediction it carried, trains the table and keeps branch statistics.
module branch_predictor #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      IFPC,
   output logic             PredTaken,
   output logic [31:0]      PredTarget,
   input  logic             EXValid,
   input  logic             EXBranch,
   input  logic             EXJump,
   input  logic [31:0]      EXPC,
   input  logic             EXTaken,
   input  logic [31:0]      EXTarget,
   input  logic             EXPredTaken,
   input  logic [31:0]      EXPredTarget,
   output logic [1:0]       Nexttype,
   output logic [31:0]      RedirectPC,
   output logic [CNT_W-1:0] BranchCnt,
   output logic [CNT_W-1:0] MispredCnt
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 32 - IDX_W - 2;

   // Next-PC selector seen by the hazard unit.
   typedef enum logic [1:0] {
      NT_PCPLUS4     = 2'b00,
      NT_BRANCH      = 2'b01,
      NT_BRANCHWRONG = 2'b10,
      NT_JUMP        = 2'b11
   } next_type_e;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         cnt_q    [ENTRIES];

   logic [CNT_W-1:0]   branch_cnt_q;
   logic [CNT_W-1:0]   mispred_cnt_q;

   logic [IDX_W-1:0]   if_idx;
   logic [TAG_W-1:0]   if_tag;
   logic               if_hit;
   logic [31:0]        if_pc_plus4;

   logic [IDX_W-1:0]   ex_idx;
   logic [TAG_W-1:0]   ex_tag;
   logic               ex_hit;
   logic [31:0]        ex_pc_plus4;
   logic               train_en;
   logic               pred_correct;
   next_type_e         next_type;

   assign if_idx      = IFPC[IDX_W+1:2];
   assign if_tag      = IFPC[31:IDX_W+2];
   assign if_pc_plus4 = IFPC + 32'd4;
   assign ex_idx      = EXPC[IDX_W+1:2];
   assign ex_tag      = EXPC[31:IDX_W+2];
   assign ex_pc_plus4 = EXPC + 32'd4;
   assign train_en    = EXValid && EXBranch;

   // Fetch-side lookup; reads the pre-update entry, no bypass from training.
   always_comb begin
      if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      PredTaken  = if_hit && cnt_q[if_idx][1];
      PredTarget = PredTaken ? target_q[if_idx] : if_pc_plus4;
   end

   // EX-stage resolution against the prediction carried down the pipe.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      next_type    = NT_PCPLUS4;
      RedirectPC   = ex_pc_plus4;
      ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      pred_correct = (EXPredTaken == EXTaken) &&
                     (!EXTaken || (EXPredTarget == EXTarget));
      if (!EXValid) begin
         next_type = NT_PCPLUS4;
      end else if (EXJump) begin
         next_type  = NT_JUMP;
         RedirectPC = EXTarget;
      end else if (EXBranch) begin
         if (pred_correct) begin
            next_type = NT_BRANCH;
         end else begin
            next_type  = NT_BRANCHWRONG;
            RedirectPC = EXTaken ? EXTarget : ex_pc_plus4;
         end
      end
   end

   assign Nexttype = next_type;

   // Table training on resolved conditional branches.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         // NOTE: the table is small and must come up invalid with weakly
         // not-taken counters, so it is held in flops with a full reset
         // rather than in a RAM macro.
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= 2'b01;
         end
      end else if (train_en) begin
         // NOTE: state uses non-blocking assignments so every entry sees
         // pre-edge values regardless of statement order.
         if (ex_hit) begin
            if (EXTaken) begin
               if (cnt_q[ex_idx] != 2'b11) cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'b01;
               target_q[ex_idx] <= EXTarget;
            end else if (cnt_q[ex_idx] != 2'b00) begin
               cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'b01;
            end
         end else if (EXTaken) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= EXTarget;
            cnt_q[ex_idx]    <= 2'b10;
         end
      end
   end

   // Saturating branch and mispredict statistics.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if ((next_type == NT_BRANCH || next_type == NT_BRANCHWRONG) &&
             (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_q <= branch_cnt_q + 1'b1;
         end
         if ((next_type == NT_BRANCHWRONG) && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_q <= mispred_cnt_q + 1'b1;
         end
      end
   end

   assign BranchCnt  = branch_cnt_q;
   assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vectors with literal expectations plus
// a behavioural table/statistics model compared on every falling clock edge.
module tb_branch_predictor;

   localparam int IDX_W = 4;
   localparam int CNT_W = 16;
   localparam int N_ENT = 1 << IDX_W;
   localparam int CMAX  = (1 << CNT_W) - 1;

   localparam logic [1:0] PCPLUS4     = 2'b00;
   localparam logic [1:0] BRANCH      = 2'b01;
   localparam logic [1:0] BRANCHWRONG = 2'b10;
   localparam logic [1:0] JUMP        = 2'b11;

   logic             clk = 1'b0;
   logic             rstn;
   logic [31:0]      IFPC;
   logic             PredTaken;
   logic [31:0]      PredTarget;
   logic             EXValid, EXBranch, EXJump, EXTaken, EXPredTaken;
   logic [31:0]      EXPC, EXTarget, EXPredTarget;
   logic [1:0]       Nexttype;
   logic [31:0]      RedirectPC;
   logic [CNT_W-1:0] BranchCnt, MispredCnt;

   int total = 0;
   int bad   = 0;

   branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .IFPC(IFPC),
      .PredTaken(PredTaken), .PredTarget(PredTarget),
      .EXValid(EXValid), .EXBranch(EXBranch), .EXJump(EXJump),
      .EXPC(EXPC), .EXTaken(EXTaken), .EXTarget(EXTarget),
      .EXPredTaken(EXPredTaken), .EXPredTarget(EXPredTarget),
      .Nexttype(Nexttype), .RedirectPC(RedirectPC),
      .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Table kept as plain integers: present flag, full upper PC bits, target,
   // and a strength value 0..3 where 2 and 3 mean "predict taken".
   bit          m_present [N_ENT];
   int unsigned m_upper   [N_ENT];
   int unsigned m_target  [N_ENT];
   int          m_strength[N_ENT];
   int          m_branches;
   int          m_wrong;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % N_ENT);
   endfunction

   function automatic int unsigned upper_of(input logic [31:0] pc);
      return pc / (4 * N_ENT);
   endfunction

   function automatic bit model_pred_taken(input logic [31:0] pc);
      int i;
      i = idx_of(pc);
      return m_present[i] && (m_upper[i] == upper_of(pc)) && (m_strength[i] >= 2);
   endfunction

   function automatic bit ex_mispredicted();
      if (EXPredTaken != EXTaken) return 1'b1;
      if (EXTaken && (EXPredTarget != EXTarget)) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_ENT; i++) begin
            m_present[i]  <= 1'b0;
            m_upper[i]    <= 0;
            m_target[i]   <= 0;
            m_strength[i] <= 1;
         end
         m_branches <= 0;
         m_wrong    <= 0;
      end else if (EXValid && EXBranch && !EXJump) begin
         int i;
         bit hit;
         i   = idx_of(EXPC);
         hit = m_present[i] && (m_upper[i] == upper_of(EXPC));
         if (hit && EXTaken) begin
            m_strength[i] <= (m_strength[i] < 3) ? m_strength[i] + 1 : 3;
            m_target[i]   <= EXTarget;
         end else if (hit) begin
            m_strength[i] <= (m_strength[i] > 0) ? m_strength[i] - 1 : 0;
         end else if (EXTaken) begin
            m_present[i]  <= 1'b1;
            m_upper[i]    <= upper_of(EXPC);
            m_target[i]   <= EXTarget;
            m_strength[i] <= 2;
         end
         if (m_branches < CMAX) m_branches <= m_branches + 1;
         if (ex_mispredicted() && m_wrong < CMAX) m_wrong <= m_wrong + 1;
      end
   end

   // Compare process: all outputs against the model on every falling edge.
   always @(negedge clk) begin
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic [1:0]  e_nt;
      logic [31:0] e_rd;
      e_pt   = model_pred_taken(IFPC);
      e_ptgt = e_pt ? m_target[idx_of(IFPC)] : IFPC + 32'd4;
      e_rd   = EXPC + 32'd4;
      if (!EXValid) begin
         e_nt = PCPLUS4;
      end else if (EXJump) begin
         e_nt = JUMP;
         e_rd = EXTarget;
      end else if (EXBranch) begin
         e_nt = ex_mispredicted() ? BRANCHWRONG : BRANCH;
         if (ex_mispredicted() && EXTaken) e_rd = EXTarget;
      end else begin
         e_nt = PCPLUS4;
      end
      check("model_pred_taken", {31'd0, PredTaken}, {31'd0, e_pt});
      check("model_pred_target", PredTarget, e_ptgt);
      check("model_nexttype", {30'd0, Nexttype}, {30'd0, e_nt});
      if (EXValid) check("model_redirect", RedirectPC, e_rd);
      check("model_branch_cnt", 32'(BranchCnt), 32'(m_branches));
      check("model_mispred_cnt", 32'(MispredCnt), 32'(m_wrong));
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic br, input logic jp, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt);
      EXValid = v; EXBranch = br; EXJump = jp; EXPC = pc;
      EXTaken = tk; EXTarget = tgt; EXPredTaken = pt; EXPredTarget = ptgt;
   endtask

   task automatic idle();
      set_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic check_pred(input string name, input logic [31:0] pc,
                             input logic pt, input logic [31:0] ptgt);
      IFPC = pc;
      #1;
      check({name, "_taken"}, {31'd0, PredTaken}, {31'd0, pt});
      check({name, "_target"}, PredTarget, ptgt);
   endtask

   task automatic check_res(input string name, input logic [1:0] nt, input logic [31:0] rd);
      #1;
      check({name, "_nexttype"}, {30'd0, Nexttype}, {30'd0, nt});
      check({name, "_redirect"}, RedirectPC, rd);
   endtask

   task automatic check_cnts(input string name, input int bc, input int mc);
      check({name, "_branch_cnt"}, 32'(BranchCnt), 32'(bc));
      check({name, "_mispred_cnt"}, 32'(MispredCnt), 32'(mc));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rstn = 1'b0;
      IFPC = 32'h0000_3000;
      idle();
      #12;
      check_pred("reset", 32'h0000_3000, 1'b0, 32'h0000_3004);
      check_cnts("reset", 0, 0);
      next_cycle();
      rstn = 1'b1;
      check_pred("post_reset", 32'h0000_3000, 1'b0, 32'h0000_3004);

      // First taken resolution of a cold branch: mispredict and allocate.
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3010, 1, 32'h0000_3000, 0, 32'h0000_3014);
      check_res("first_taken", BRANCHWRONG, 32'h0000_3000);
      next_cycle();
      idle();
      check_pred("after_alloc", 32'h0000_3010, 1'b1, 32'h0000_3000);
      check_cnts("after_alloc", 1, 1);

      // Three correctly predicted taken resolutions.
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         set_ex(1, 1, 0, 32'h0000_3010, 1, 32'h0000_3000, 1, 32'h0000_3000);
         check_res("taken_correct", BRANCH, 32'h0000_3014);
      end

      // Two not-taken resolutions walk the counter from 3 down to 1.
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         set_ex(1, 1, 0, 32'h0000_3010, 0, 32'h0000_3000, 1, 32'h0000_3000);
         check_res("not_taken_wrong", BRANCHWRONG, 32'h0000_3014);
      end
      next_cycle();
      idle();
      check_pred("weakened", 32'h0000_3010, 1'b0, 32'h0000_3014);
      check_cnts("weakened", 6, 3);

      // Re-strengthen, then alias it out with 0x3050.
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3010, 1, 32'h0000_3000, 0, 32'h0000_3014);
      check_res("retrain1", BRANCHWRONG, 32'h0000_3000);
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3010, 1, 32'h0000_3000, 1, 32'h0000_3000);
      check_res("retrain2", BRANCH, 32'h0000_3014);
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3050, 1, 32'h0000_3100, 0, 32'h0000_3054);
      check_res("alias_alloc", BRANCHWRONG, 32'h0000_3100);
      next_cycle();
      idle();
      check_pred("alias_old", 32'h0000_3010, 1'b0, 32'h0000_3014);
      check_pred("alias_new", 32'h0000_3050, 1'b1, 32'h0000_3100);
      check_cnts("alias", 9, 5);

      // Jump: redirects, never trains, never counts.
      next_cycle();
      set_ex(1, 0, 1, 32'h0000_3020, 0, 32'h0000_3400, 0, 32'h0000_3024);
      check_res("jump", JUMP, 32'h0000_3400);
      next_cycle();
      idle();
      check_pred("after_jump", 32'h0000_3020, 1'b0, 32'h0000_3024);
      check_cnts("after_jump", 9, 5);

      // Bubble carrying a stale branch flag.
      next_cycle();
      set_ex(0, 1, 0, 32'h0000_3020, 1, 32'h0000_3200, 0, 32'h0000_3024);
      #1;
      check("bubble_nexttype", {30'd0, Nexttype}, {30'd0, PCPLUS4});
      next_cycle();
      idle();
      check_pred("after_bubble", 32'h0000_3020, 1'b0, 32'h0000_3024);
      check_cnts("after_bubble", 9, 5);

      // Not-taken miss: correct, no allocation.
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3030, 0, 32'h0000_3300, 0, 32'h0000_3034);
      check_res("nt_miss", BRANCH, 32'h0000_3034);
      next_cycle();
      idle();
      check_pred("after_nt_miss", 32'h0000_3030, 1'b0, 32'h0000_3034);
      check_cnts("after_nt_miss", 10, 5);

      // Same-cycle lookup and allocation of one index: no bypass.
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3070, 1, 32'h0000_3700, 0, 32'h0000_3074);
      check_pred("same_cycle", 32'h0000_3070, 1'b0, 32'h0000_3074);
      check("same_cycle_nexttype", {30'd0, Nexttype}, {30'd0, BRANCHWRONG});
      next_cycle();
      idle();
      check_pred("after_same_cycle", 32'h0000_3070, 1'b1, 32'h0000_3700);
      check_cnts("after_same_cycle", 11, 6);

      // Predicted taken with the wrong target.
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3050, 1, 32'h0000_3180, 1, 32'h0000_3100);
      check_res("bad_target", BRANCHWRONG, 32'h0000_3180);
      next_cycle();
      idle();
      check_pred("new_target", 32'h0000_3050, 1'b1, 32'h0000_3180);
      check_cnts("new_target", 12, 7);

      // Asynchronous reset mid-stream.
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_taken", {31'd0, PredTaken}, 32'd0);
      check("async_rst_target", PredTarget, 32'h0000_3054);
      check_cnts("async_rst", 0, 0);
      next_cycle();
      next_cycle();
      rstn = 1'b1;
      check_pred("after_rst_3050", 32'h0000_3050, 1'b0, 32'h0000_3054);
      check_pred("after_rst_3070", 32'h0000_3070, 1'b0, 32'h0000_3074);

      // Statistics saturation: every resolution here is a mispredict.
      next_cycle();
      set_ex(1, 1, 0, 32'h0000_3090, 1, 32'h0000_3000, 0, 32'h0000_3094);
      for (int k = 0; k < (1 << CNT_W) + 5; k++) @(posedge clk);
      #1;
      idle();
      next_cycle();
      check_cnts("saturate", CMAX, CMAX);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
